// File: rtl/alu_arbiter_pkg.sv
// Shared opcode constants and arbiter FSM state type.
package alu_arbiter_pkg;

  // ALU opcodes; anything above OPR_MAX is illegal.
  localparam int unsigned OPR_ADD = 0;
  localparam int unsigned OPR_SUB = 1;
  localparam int unsigned OPR_SHL = 2;
  localparam int unsigned OPR_XOR = 3;
  localparam int unsigned OPR_SHR = 4;
  localparam int unsigned OPR_OR  = 5;
  localparam int unsigned OPR_AND = 6;
  localparam int unsigned OPR_MAX = 6;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 64-bit ALU shared by the arbiter's requesters.
module ALU_64bit_RISCV
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned OPR_W = 4
) (
  input  logic [OPR_W-1:0] opr,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  result,
  output logic             err
);

  localparam int unsigned ShW = $clog2(XLEN);

  // The whole of b is the shift amount, so anything >= XLEN shifts everything out.
  logic big_shamt;
  assign big_shamt = (b >= XLEN'(XLEN));

  // Opcode decode; illegal opcodes give zero data with err set.
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (opr)
      OPR_W'(OPR_ADD): result = a + b;
      OPR_W'(OPR_SUB): result = a - b;
      OPR_W'(OPR_SHL): result = big_shamt ? '0 : (a << b[ShW-1:0]);
      OPR_W'(OPR_XOR): result = a ^ b;
      OPR_W'(OPR_SHR): result = big_shamt ? '0 : (a >> b[ShW-1:0]);
      OPR_W'(OPR_OR):  result = {{(XLEN-1){1'b0}}, ((|a) || (|b))};
      OPR_W'(OPR_AND): result = {{(XLEN-1){1'b0}}, ((|a) && (|b))};
      default:         err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared ALU.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned OPR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPR_W-1:0] req0_opr,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [XLEN-1:0]  req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [XLEN-1:0]  rsp0_data,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPR_W-1:0] req1_opr,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [XLEN-1:0]  req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [XLEN-1:0]  rsp1_data,
  output logic             rsp1_err
);

  state_t           state_q;
  logic             ptr_q;
  logic             winner_q;
  logic [OPR_W-1:0] opr_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  res_q;
  logic             err_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;

  logic             grant0;
  logic             grant1;
  logic [XLEN-1:0]  alu_result;
  logic             alu_err;

  // Contended grant goes to ptr; a lone requester always wins.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || !ptr_q);
    grant1 = req1_valid && (!req0_valid || ptr_q);
  end

  assign req0_ready = (state_q == StIdle) && !rst && grant0;
  assign req1_ready = (state_q == StIdle) && !rst && grant1;

  ALU_64bit_RISCV #(
    .XLEN  (XLEN),
    .OPR_W (OPR_W)
  ) u_alu (
    .opr    (opr_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .err    (alu_err)
  );

  // Arbitration FSM: accept one request, run it for one cycle, hold the result until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= 1'b0;
      winner_q     <= 1'b0;
      opr_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      err_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req0_valid && req0_ready) begin
            opr_q    <= req0_opr;
            a_q      <= req0_a;
            b_q      <= req0_b;
            winner_q <= 1'b0;
            state_q  <= StExec;
          end else if (req1_valid && req1_ready) begin
            opr_q    <= req1_opr;
            a_q      <= req1_a;
            b_q      <= req1_b;
            winner_q <= 1'b1;
            state_q  <= StExec;
          end
        end
        StExec: begin
          res_q        <= alu_result;
          err_q        <= alu_err;
          rsp0_valid_q <= !winner_q;
          rsp1_valid_q <= winner_q;
          state_q      <= StResp;
        end
        StResp: begin
          if ((!winner_q && rsp0_ready) || (winner_q && rsp1_ready)) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            ptr_q        <= !winner_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Only the winner's port shows the held result; the other port stays at zero.
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_valid_q ? res_q : '0;
  assign rsp1_data  = rsp1_valid_q ? res_q : '0;
  assign rsp0_err   = rsp0_valid_q && err_q;
  assign rsp1_err   = rsp1_valid_q && err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios followed by random traffic.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_opr, req1_opr;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [63:0] rsp0_data, rsp1_data;
  logic        rsp0_err, rsp1_err;

  alu_arbiter #(
    .XLEN  (64),
    .OPR_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_opr   (req0_opr),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp0_err   (rsp0_err),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_opr   (req1_opr),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .rsp1_err   (rsp1_err)
  );

  always #5 clk = ~clk;

  // Reference model state: one outstanding transaction at most.
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          m_outst = 1'b0;
  bit          m_win   = 1'b0;
  bit          m_ptr   = 1'b0;
  int          m_age   = 0;
  bit          rst_prev = 1'b0;
  logic [64:0] exp_q[$];

  // {err, data} from the opcode table, using plain SV operators.
  function automatic logic [64:0] ref_alu(logic [3:0] op, logic [63:0] a, logic [63:0] b);
    case (op)
      4'd0:    return {1'b0, a + b};
      4'd1:    return {1'b0, a - b};
      4'd2:    return {1'b0, a << b};
      4'd3:    return {1'b0, a ^ b};
      4'd4:    return {1'b0, a >> b};
      4'd5:    return {1'b0, 63'd0, ((a != 0) || (b != 0))};
      4'd6:    return {1'b0, 63'd0, ((a != 0) && (b != 0))};
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares grants and responses against the model mid-cycle.
  always @(negedge clk) begin
    logic        e_r0, e_r1, e_v0, e_v1;
    logic [64:0] e;
    if (rst_prev) begin
      chk("rst_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
      chk("rst_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
      chk("rst_rsp0_data", rsp0_data, 64'd0);
      chk("rst_rsp1_data", rsp1_data, 64'd0);
      chk("rst_rsp0_err", {63'd0, rsp0_err}, 64'd0);
      chk("rst_rsp1_err", {63'd0, rsp1_err}, 64'd0);
    end
    if (rst) begin
      chk("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
      chk("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
      m_outst = 1'b0;
      m_ptr   = 1'b0;
      m_age   = 0;
      exp_q.delete();
    end else begin
      if (m_outst) m_age++;
      e_r0 = !m_outst && req0_valid && (!req1_valid || !m_ptr);
      e_r1 = !m_outst && req1_valid && (!req0_valid || m_ptr);
      chk("req0_ready", {63'd0, req0_ready}, {63'd0, e_r0});
      chk("req1_ready", {63'd0, req1_ready}, {63'd0, e_r1});
      e_v0 = m_outst && !m_win && (m_age >= 2);
      e_v1 = m_outst && m_win && (m_age >= 2);
      chk("rsp0_valid", {63'd0, rsp0_valid}, {63'd0, e_v0});
      chk("rsp1_valid", {63'd0, rsp1_valid}, {63'd0, e_v1});
      if (m_outst && (m_age >= 2) && (exp_q.size() > 0)) begin
        e = exp_q[0];
        if (!m_win) begin
          chk("rsp0_data", rsp0_data, e[63:0]);
          chk("rsp0_err", {63'd0, rsp0_err}, {63'd0, e[64]});
        end else begin
          chk("rsp1_data", rsp1_data, e[63:0]);
          chk("rsp1_err", {63'd0, rsp1_err}, {63'd0, e[64]});
        end
        if (m_win ? rsp1_ready : rsp0_ready) begin
          void'(exp_q.pop_front());
          m_outst = 1'b0;
          m_ptr   = !m_win;
        end
      end
      if (m_outst && (m_age > 40)) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_timeout: waited %0d cycles, required at most 40", m_age);
        m_outst = 1'b0;
        exp_q.delete();
      end
      if (req0_valid && req0_ready) begin
        exp_q.push_back(ref_alu(req0_opr, req0_a, req0_b));
        m_outst = 1'b1;
        m_win   = 1'b0;
        m_age   = 0;
      end else if (req1_valid && req1_ready) begin
        exp_q.push_back(ref_alu(req1_opr, req1_a, req1_b));
        m_outst = 1'b1;
        m_win   = 1'b1;
        m_age   = 0;
      end
    end
    rst_prev = rst;
  end

  // One cycle: observe handshakes mid-cycle, then drop accepted valids just after the edge.
  task automatic tick();
    logic t0, t1;
    @(negedge clk);
    t0 = req0_valid && req0_ready;
    t1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (t0) req0_valid = 1'b0;
    if (t1) req1_valid = 1'b0;
  endtask

  task automatic set_req(int n, logic [3:0] op, logic [63:0] a, logic [63:0] b);
    if (n == 0) begin
      req0_opr = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_opr = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      if (!req0_valid && !req1_valid && !m_outst) break;
      tick();
    end
  endtask

  task automatic rand_req(int n);
    logic [3:0]  op;
    logic [63:0] a, b;
    op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(7, 15));
    a  = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       b = 64'($urandom_range(0, 70));
      1:       b = 64'($urandom_range(0, 1));
      default: b = {$urandom, $urandom};
    endcase
    if ($urandom_range(0, 7) == 0) a = 64'd0;
    set_req(n, op, a, b);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_opr = '0; req0_a = '0; req0_b = '0;
    req1_opr = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Simple add on requester 0.
    set_req(0, 4'd0, 64'd5, 64'd7);
    wait_idle();

    // Contention right after reset: requester 0 first, then 1.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    set_req(0, 4'd1, 64'd3, 64'd5);
    set_req(1, 4'd3, 64'hF0, 64'hFF);
    wait_idle();

    // Shift boundaries.
    set_req(0, 4'd2, 64'd1, 64'd63);
    wait_idle();
    set_req(0, 4'd4, '1, 64'd64);
    wait_idle();

    // Illegal opcode followed by a legal one.
    set_req(1, 4'hF, 64'h1234, 64'h5678);
    wait_idle();
    set_req(1, 4'd5, 64'd0, 64'd9);
    wait_idle();

    // Response backpressure on requester 1 with requester 0 waiting.
    rsp1_ready = 1'b0;
    set_req(1, 4'd3, 64'hAAAA, 64'h5555);
    for (int i = 0; i < 10 && req1_valid; i++) tick();
    set_req(0, 4'd0, 64'd100, 64'd200);
    repeat (7) tick();
    rsp1_ready = 1'b1;
    wait_idle();

    // Reset while the ALU cycle is in flight; then contention must favour requester 0.
    set_req(0, 4'd0, 64'd1, 64'd2);
    for (int i = 0; i < 10 && req0_valid; i++) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    set_req(0, 4'd6, 64'd4, 64'd0);
    set_req(1, 4'd1, 64'd0, 64'd1);
    wait_idle();
    set_req(1, 4'd0, '1, 64'd1);
    wait_idle();

    // Random traffic with withdrawals and random response backpressure.
    for (int c = 0; c < 2000; c++) begin
      if (!req0_valid && ($urandom_range(0, 2) == 0)) rand_req(0);
      else if (req0_valid && ($urandom_range(0, 15) == 0)) req0_valid = 1'b0;
      if (!req1_valid && ($urandom_range(0, 2) == 0)) rand_req(1);
      else if (req1_valid && ($urandom_range(0, 15) == 0)) req1_valid = 1'b0;
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      tick();
    end

    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    wait_idle();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
